// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter.
// DATA register (BASE_ADDR) pushes a byte into a TX FIFO; STATUS register
// (BASE_ADDR+4) reports occupancy and flags and clears the sticky overflow.
// A four-state FSM drains the FIFO onto the serial line as 8N1 frames.
//
// Bus handshake: there is no stall. A store is one bus_write pulse and is
// consumed on the rising edge that ends that cycle. A load drives
// bus_read_data combinationally in the cycle bus_read is high. An unselected
// or idle bus yields zero, so several slaves can be OR-ed together.
module bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic        bus_write,
    input  logic        bus_read,
    output logic [31:0] bus_read_data,
    output logic        tx
);

    localparam int              AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW          = AW + 1;
    localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0]     BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   FULL_COUNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FSM state and transmit datapath
    state_t      state_q;
    state_t      state_d;
    logic [15:0] baud_q;
    logic [15:0] baud_d;
    logic [2:0]  bit_q;
    logic [2:0]  bit_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        tx_q;
    logic        tx_d;
    logic        pop;

    // FIFO storage and bookkeeping
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    // Bus decode
    logic        sel_data;
    logic        sel_status;
    logic        push_req;
    logic        push_ok;
    logic        ovf_set;
    logic        ovf_clear;
    logic        busy;
    logic [31:0] status_word;

    // Only the low byte of a DATA store carries payload.
    logic        unused_write_bits;

    assign sel_data    = (bus_address == BASE_ADDR);
    assign sel_status  = (bus_address == STATUS_ADDR);
    assign push_req    = bus_write && sel_data;
    assign ovf_clear   = bus_write && sel_status && bus_write_data[3];

    assign fifo_full   = (count_q == FULL_COUNT);
    assign fifo_empty  = (count_q == '0);
    assign fifo_head   = fifo_mem[rd_ptr_q];

    // A full FIFO still accepts a push when the FSM pops in the same cycle.
    assign push_ok     = push_req && (!fifo_full || pop);
    assign ovf_set     = push_req && fifo_full && !pop;

    assign busy        = (state_q != IDLE);
    assign status_word = {{(24 - CW){1'b0}}, count_q, 4'b0000,
                          overflow_q, fifo_empty, fifo_full, busy};

    assign bus_read_data = (bus_read && sel_status) ? status_word : 32'd0;
    assign tx            = tx_q;

    assign unused_write_bits = ^bus_write_data[31:8];

    // FIFO storage: written only on an accepted push, no reset needed.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            fifo_mem[wr_ptr_q] <= bus_write_data[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            // A drop in the same cycle as a clear leaves the flag set.
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (ovf_clear) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // FSM state register and transmit datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: each non-idle state lasts CLKS_PER_BIT cycles per bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    state_d = START;
                end
            end

            START: begin
                if (baud_q == 16'd0) begin
                    // Present bit 0 and pre-shift so shift_q[0] is always the next bit.
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                    baud_d  = BAUD_RELOAD;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end

            DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end

            STOP: begin
                if (baud_q == 16'd0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_RELOAD;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        baud_d  = 16'd0;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Accepted bytes go into exp_q; a serial monitor decodes each frame on tx
// and compares it to the head of exp_q.
module tb_bus_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = BASE + 32'd4;
    localparam int          CPB  = 4;

    logic        clock;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic        bus_write;
    logic        bus_read;
    logic [31:0] bus_read_data;
    logic        tx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frame_starts = 0;

    bus_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus_address    (bus_address),
        .bus_write_data (bus_write_data),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_read_data  (bus_read_data),
        .tx             (tx)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit bsy);
        logic [23:0] c;
        c = 24'(cnt);
        return {c, 4'b0000, ovf, (cnt == 0), (cnt == 8), bsy};
    endfunction

    // driver tasks: called 1ns after a rising edge, return 1ns after the next
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus_address    = a;
        bus_write_data = d;
        bus_write      = 1'b1;
        @(posedge clock);
        #1;
        bus_write      = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus_address = a;
        bus_read    = 1'b1;
        @(negedge clock);
        d = bus_read_data;
        @(posedge clock);
        #1;
        bus_read    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int max_reads);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < max_reads; i++) begin
            bus_rd(STAT, d);
            if (d == 32'h0000_0004) break;
        end
        check(tag, d, 32'h0000_0004);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // scoreboard: decode frames at mid-bit and compare with exp_q
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [9:0] mon_bits   = '0;

    always @(negedge clock) begin
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                frame_starts++;
                start_q.push_back(cyc);
            end
            if (mon_active) begin
                if (mon_cnt % CPB == CPB / 2) mon_bits[mon_cnt / CPB] = tx;
                if (mon_cnt == 9 * CPB + CPB / 2) begin
                    check("sb_framing", {mon_bits[0], mon_bits[9]}, 2'b01);
                    if (exp_q.size() > 0) begin
                        check("sb_byte", mon_bits[8:1], exp_q.pop_front());
                    end else begin
                        check("sb_extra_frame", mon_bits[8:1], 9'h100);
                    end
                    mon_active = 1'b0;
                end
                mon_cnt++;
            end
        end
    end

    // stimulus
    initial begin
        logic [31:0] d;
        logic [39:0] wave_got;
        logic [39:0] wave_exp;
        logic [39:0] busy_got;
        logic [7:0]  b;
        logic [7:0]  byte55;
        int          snap;

        reset          = 1'b1;
        bus_address    = '0;
        bus_write_data = '0;
        bus_write      = 1'b0;
        bus_read       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clock);
        check("rst_tx", tx, 1'b1);
        @(posedge clock);
        #1;
        bus_rd(STAT, d);
        check("rst_status", d, status_word(0, 0, 0));

        // single frame, exact waveform and busy window
        byte55 = 8'h55;
        bus_wr(BASE, 32'hFFFF_FF55);
        exp_q.push_back(byte55);
        bus_address = STAT;
        bus_read    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            wave_got[i] = tx;
            busy_got[i] = bus_read_data[0];
            if (i / CPB == 0)      wave_exp[i] = 1'b0;
            else if (i / CPB == 9) wave_exp[i] = 1'b1;
            else                   wave_exp[i] = byte55[i / CPB - 1];
        end
        check("t1_tx_wave", wave_got, wave_exp);
        check("t1_busy", busy_got, {40{1'b1}});
        @(posedge clock);
        @(negedge clock);
        check("t1_status_after", bus_read_data, 32'h0000_0004);
        @(posedge clock);
        #1;
        bus_read = 1'b0;
        check("t1_sb_drained", exp_q.size(), 0);

        // nine back-to-back writes from idle, then overflow and clear
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_wr(BASE, {24'($urandom), b});
            exp_q.push_back(b);
        end
        bus_rd(STAT, d);
        check("t2_full", d, status_word(8, 0, 1));
        bus_wr(BASE, 32'h0000_00EE);
        bus_rd(STAT, d);
        check("t2_overflow", d, status_word(8, 1, 1));
        bus_wr(STAT, 32'h0000_0008);
        bus_rd(STAT, d);
        check("t2_ovf_clear", d, status_word(8, 0, 1));
        wait_idle("t2_idle", 9 * 40 + 40);

        // two frames chained with no idle gap
        start_q.delete();
        bus_wr(BASE, 32'h0000_00A1);
        exp_q.push_back(8'hA1);
        bus_wr(BASE, 32'h0000_00B2);
        exp_q.push_back(8'hB2);
        wait_idle("t3_idle", 120);
        check("t3_frames", start_q.size(), 2);
        check("t3_gap", (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : 0, 10 * CPB);

        // full FIFO, push lands on the STOP-to-START pop edge
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_wr(BASE, {24'h0, b});
            exp_q.push_back(b);
        end
        idle_cycles(32);
        b = 8'($urandom_range(0, 255));
        bus_wr(BASE, {24'h0, b});
        exp_q.push_back(b);
        bus_rd(STAT, d);
        check("t4_push_on_pop", d, status_word(8, 0, 1));
        wait_idle("t4_idle", 10 * 40 + 40);

        // reset during DATA bit 3 with three bytes queued, store in the reset cycle
        for (int i = 0; i < 4; i++) begin
            bus_wr(BASE, {24'h0, 8'($urandom_range(0, 255))});
        end
        idle_cycles(15);
        reset          = 1'b1;
        bus_address    = BASE;
        bus_write_data = 32'h0000_0077;
        bus_write      = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset     = 1'b0;
        bus_write = 1'b0;
        snap      = frame_starts;
        @(negedge clock);
        check("t5_tx_after_reset", tx, 1'b1);
        @(posedge clock);
        #1;
        bus_rd(STAT, d);
        check("t5_status", d, 32'h0000_0004);
        idle_cycles(100);
        check("t5_no_frames", frame_starts, snap);

        // unmapped address, DATA read, gated read, ignored STATUS bits
        bus_rd(BASE + 32'd8, d);
        check("t6_rd_unmapped", d, 32'h0);
        bus_wr(BASE + 32'd8, 32'h0000_005A);
        idle_cycles(3);
        bus_rd(STAT, d);
        check("t6_wr_unmapped", d, 32'h0000_0004);
        check("t6_no_frame", frame_starts, snap);
        bus_rd(BASE, d);
        check("t6_rd_data", d, 32'h0);
        bus_address = STAT;
        bus_read    = 1'b0;
        @(negedge clock);
        check("t6_rd_gated", bus_read_data, 32'h0);
        @(posedge clock);
        #1;
        bus_wr(STAT, 32'hFFFF_FFF7);
        bus_rd(STAT, d);
        check("t6_status_wr_ignored", d, 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
